// File: rtl/uart_rx_core.sv
// uart_rx_core: receive half of the UART.
// Deserializes start / DATA_WIDTH data bits (LSB first) / even parity / stop
// frames from the RX line, pushes good bytes into the RX FIFO write port and
// keeps sticky parity, framing and overrun flags.

`ifndef Fifo_Full
`define Fifo_Full 4'b0001
`endif

module uart_rx_core #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_uart,
    input  logic                  RX,
    output logic [DATA_WIDTH-1:0] fwdata,
    output logic                  fwrite,
    input  logic [3:0]            fwstatus,
    input  logic                  err_clr,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  rx_busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Start bit is re-checked at HALF; every later bit is sampled on the
    // last count of its bit period, which keeps the frame spacing exact so a
    // back-to-back start edge lands in IDLE right after the stop evaluation.
    localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q,      state_d;
    logic [CW-1:0]         cnt_q,        cnt_d;
    logic [BW-1:0]         bit_idx_q,    bit_idx_d;
    logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
    logic                  par_bit_q,    par_bit_d;
    logic [1:0]            sync_q,       sync_d;
    logic [DATA_WIDTH-1:0] fwdata_q,     fwdata_d;
    logic                  fwrite_q,     fwrite_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  overrun_q,    overrun_d;

    logic                  rx_s;
    logic                  fifo_full;
    logic                  set_parity;
    logic                  set_frame;
    logic                  set_overrun;
    logic [DATA_WIDTH:0]   shift_tmp;

    assign rx_s      = sync_q[1];
    assign fifo_full = |(fwstatus & `Fifo_Full);
    assign shift_tmp = {rx_s, shreg_q};

    // Two-flop synchronizer for the asynchronous RX line (idles high).
    always_comb begin
        sync_d = {sync_q[0], RX};
    end

    // Frame FSM: bit timing, shifting, stop-bit evaluation and flag updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        fwdata_d    = fwdata_q;
        fwrite_d    = 1'b0;
        set_parity  = 1'b0;
        set_frame   = 1'b0;
        set_overrun = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable_uart && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high: a glitch, not a start bit.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = shift_tmp[DATA_WIDTH:1];
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s) begin
                        set_frame = 1'b1;
                    end else if (par_bit_q != ^shreg_q) begin
                        set_parity = 1'b1;
                    end else if (fifo_full) begin
                        set_overrun = 1'b1;
                    end else begin
                        fwrite_d = 1'b1;
                        fwdata_d = shreg_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Disabling the receiver abandons any frame in flight silently.
        if (!enable_uart) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            bit_idx_d   = '0;
            fwrite_d    = 1'b0;
            fwdata_d    = fwdata_q;
            set_parity  = 1'b0;
            set_frame   = 1'b0;
            set_overrun = 1'b0;
        end

        // Sticky flags: a new error in the same cycle beats err_clr.
        parity_err_d = set_parity  | (parity_err_q & ~err_clr);
        frame_err_d  = set_frame   | (frame_err_q  & ~err_clr);
        overrun_d    = set_overrun | (overrun_q    & ~err_clr);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            sync_q       <= 2'b11;
            fwdata_q     <= '0;
            fwrite_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            sync_q       <= sync_d;
            fwdata_q     <= fwdata_d;
            fwrite_q     <= fwrite_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign fwdata     = fwdata_q;
    assign fwrite     = fwrite_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core. A behavioural
// transmitter drives RX; expected bytes are queued when a good frame is sent
// and popped whenever the receiver raises fwrite.

`ifndef Fifo_Full
`define Fifo_Full 4'b0001
`endif

module tb_uart_rx_core;

    localparam int DW  = 8;
    localparam int CPB = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable_uart;
    logic          RX;
    logic [DW-1:0] fwdata;
    logic          fwrite;
    logic [3:0]    fwstatus;
    logic          err_clr;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          rx_busy;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];

    uart_rx_core #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_uart (enable_uart),
        .RX          (RX),
        .fwdata      (fwdata),
        .fwrite      (fwrite),
        .fwstatus    (fwstatus),
        .err_clr     (err_clr),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle (inputs change and outputs are sampled on the
    // falling edge) and retire any FIFO write against the scoreboard.
    task automatic step();
        logic [DW-1:0] e;
        @(negedge clk);
        if (fwrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fwrite_unexpected: got write of %02h, required no write", fwdata);
            end else begin
                e = exp_q.pop_front();
                if (fwdata !== e) begin
                    failures++;
                    $display("FAIL fwdata: got %02h, required %02h", fwdata, e);
                end else begin
                    $display("write ok: fwdata=%02h", fwdata);
                end
            end
        end
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        repeat (CPB) step();
    endtask

    // Data, parity and stop bits; par_flip=1 sends the wrong parity.
    task automatic send_tail(input logic [DW-1:0] d, input logic par_flip, input logic stop_bit);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit((^d) ^ par_flip);
        drive_bit(stop_bit);
        RX = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par_flip, input logic stop_bit);
        drive_bit(1'b0);
        send_tail(d, par_flip, stop_bit);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable_uart = 1'b1; RX = 1'b1; fwstatus = 4'h0; err_clr = 1'b0;
        repeat (3) step();
        checks++; if (fwdata !== 8'h00)  begin failures++; $display("FAIL reset_fwdata: got %02h, required 00", fwdata); end
        checks++; if (fwrite !== 1'b0)   begin failures++; $display("FAIL reset_fwrite: got %b, required 0", fwrite); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got p=%b f=%b o=%b, required 000", parity_err, frame_err, overrun);
        end
        checks++; if (rx_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %b, required 0", rx_busy); end
        reset_n = 1'b1;
        repeat (4) step();
        $display("reset: outputs checked");
    endtask

    task automatic test_good_frame();
        exp_q.push_back(8'hA5);
        drive_bit(1'b0);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL good_busy_mid: got %b, required 1", rx_busy); end
        send_tail(8'hA5, 1'b0, 1'b1);
        repeat (6) step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL good_write_missing: got %0d pending, required 0", exp_q.size()); end
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
            failures++; $display("FAIL good_flags: got %b, required 000", {parity_err, frame_err, overrun});
        end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL good_busy_end: got %b, required 0", rx_busy); end
        $display("good frame A5 done");
    endtask

    task automatic test_parity_err();
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (6) step();
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL parity_set: got %b, required 1", parity_err); end
        checks++; if (frame_err !== 1'b0)  begin failures++; $display("FAIL parity_frame: got %b, required 0", frame_err); end
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL parity_clr: got %b, required 0", parity_err); end
        $display("parity error frame 3C done");
    endtask

    task automatic test_frame_err();
        send_frame(8'h81, 1'b0, 1'b0);
        repeat (6) step();
        checks++; if (frame_err !== 1'b1)  begin failures++; $display("FAIL frame_set: got %b, required 1", frame_err); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL frame_parity: got %b, required 0", parity_err); end
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        checks++; if (frame_err !== 1'b0)  begin failures++; $display("FAIL frame_clr: got %b, required 0", frame_err); end
        $display("framing error frame 81 done");
    endtask

    task automatic test_glitch();
        logic seen_busy;
        seen_busy = 1'b0;
        RX = 1'b0; step(); RX = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rx_busy === 1'b1) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b1) begin failures++; $display("FAIL glitch_start: got busy_seen=%b, required 1", seen_busy); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_idle: got %b, required 0", rx_busy); end
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
            failures++; $display("FAIL glitch_flags: got %b, required 000", {parity_err, frame_err, overrun});
        end
        $display("glitch rejected");
    endtask

    task automatic test_overrun();
        fwstatus = `Fifo_Full;
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (6) step();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b, required 1", overrun); end
        fwstatus = 4'h0;
        exp_q.push_back(8'h56);
        send_frame(8'h56, 1'b0, 1'b1);
        repeat (6) step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL overrun_write_missing: got %0d pending, required 0", exp_q.size()); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clr: got %b, required 0", overrun); end
        $display("overrun scenario done");
    endtask

    task automatic test_enable_drop();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        enable_uart = 1'b0;
        step(); step();
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL disable_idle: got %b, required 0", rx_busy); end
        RX = 1'b1;
        repeat (30) step();
        enable_uart = 1'b1;
        repeat (4) step();
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
            failures++; $display("FAIL disable_flags: got %b, required 000", {parity_err, frame_err, overrun});
        end
        $display("enable drop mid-frame done");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] stream [4];
        stream[0] = 8'h00; stream[1] = 8'hFF; stream[2] = 8'h55; stream[3] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(stream[i]);
            send_frame(stream[i], 1'b0, 1'b1);
        end
        repeat (6) step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_writes: got %0d pending, required 0", exp_q.size()); end
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
            failures++; $display("FAIL b2b_flags: got %b, required 000", {parity_err, frame_err, overrun});
        end
        $display("back-to-back stream done");
    endtask

    task automatic test_reset_mid_frame();
        exp_q.push_back(8'h34);
        send_frame(8'h34, 1'b0, 1'b1);
        // Second frame cut short by reset.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        reset_n = 1'b0;
        RX = 1'b1;
        step();
        checks++; if (fwdata !== 8'h00) begin failures++; $display("FAIL midrst_fwdata: got %02h, required 00", fwdata); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b, required 0", rx_busy); end
        checks++; if (fwrite !== 1'b0)  begin failures++; $display("FAIL midrst_fwrite: got %b, required 0", fwrite); end
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1);
        repeat (6) step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_recover: got %0d pending, required 0", exp_q.size()); end
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
            failures++; $display("FAIL midrst_flags: got %b, required 000", {parity_err, frame_err, overrun});
        end
        $display("reset mid-frame and recovery done");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
